clk_period_monitor: RTL and testbench
=====================================

// Module: clk_period_monitor
// PURPOSE
//  Receive-side checker for divided clocks produced in clk_in domain. Samples a slow clock-like
//  input, measures period and high time in clk_in cycles, and reports lock once the period is
//  stable. Used to verify and monitor divider outputs (e.g. 8-cycle, 4-high) in the same design.
// PARAMETERS
//  CNT_W        8   width of cycle counter and of period/high_time outputs
//  LOCK_CNT     4   consecutive equal period measurements required to assert locked
//  SYNC_STAGES  2   synchronizer flops on sig_in (>=2)
// PORTS
//  clk_in     in   1      system clock; all logic on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  sig_in     in   1      monitored divided clock (treated as async data)
//  clr        in   1      synchronous clear: return to IDLE, clear all outputs incl. overflow
//  meas_valid out  1      1-cycle pulse: period/high_time updated
//  period     out  CNT_W  last measured rise-to-rise distance, clk_in cycles
//  high_time  out  CNT_W  last measured rise-to-fall distance, clk_in cycles
//  locked     out  1      LOCK_CNT consecutive identical periods seen
//  overflow   out  1      sticky: counter saturated with no edge
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state IDLE, cnt=0, match_cnt=0, sync chain 0.
//  - sig_in -> SYNC_STAGES flops -> s; prev register; rise = s & ~prev, fall = ~s & prev.
//    Edge pulse appears SYNC_STAGES+1 cycles after sig_in changes.
//  - cnt: on rise cycle cnt<=1; else cnt<=cnt+1, saturating at 2^CNT_W-1.
//  - FSM IDLE/MEAS_HIGH/MEAS_LOW:
//    IDLE: rise -> MEAS_HIGH (no measurement); fall ignored.
//    MEAS_HIGH: fall -> hi_cap<=cnt, MEAS_LOW.
//    MEAS_LOW: rise -> period<=cnt, high_time<=hi_cap, meas_valid<=1 (next cycle), MEAS_HIGH.
//    Any state except IDLE: cnt==2^CNT_W-1 with no edge -> overflow<=1, locked<=0,
//    match_cnt<=0, IDLE.
//  - Example: rise every 8 cycles, 4 high -> period=8, high_time=4.
//  - High time of 1 cycle is legal (fall on cycle after rise).
//  - Lock: on each measurement, if match_cnt==0 or period_new!=period_prev -> match_cnt<=1;
//    else match_cnt<=min(match_cnt+1,LOCK_CNT). locked = (match_cnt==LOCK_CNT), registered,
//    updated same cycle as meas_valid. Mismatch drops locked on that meas_valid.
//  - clr has priority over any edge or overflow in the same cycle; clr clears outputs to
//    reset values; sync chain not cleared.
//  - overflow stays 1 until clr or reset; measurement resumes from IDLE.
//  - Reset mid-measurement: immediate async return to reset values; no partial result.
// STRUCTURE
//  - Package clk_mon_pkg: state enum (IDLE, MEAS_HIGH, MEAS_LOW), default CNT_W/LOCK_CNT.
//  - Sub-module sync_edge_det: SYNC_STAGES synchronizer + prev reg, outputs s, rise, fall.
//  - Top: counter, FSM, capture regs, lock counter.
// TESTING
//  1 Reset with sig_in toggling -> all outputs 0 throughout; after release first meas_valid
//    only after second rise.
//  2 sig_in = 8-cycle clock, 4 high -> meas_valid every 8 cycles, period=8, high_time=4;
//    locked=1 on 4th meas_valid.
//  3 Switch to 10-cycle clock, 3 high -> first meas_valid at period=10, high_time=3, locked=0;
//    relock on 4th 10-cycle measurement.
//  4 sig_in held high 300 cycles after a rise -> overflow=1, locked=0, no meas_valid;
//    restart clock -> measurements resume, overflow stays 1 until clr.
//  5 clr asserted in same cycle as rise pulse -> state IDLE, all outputs 0;
//    next meas_valid needs two further rises.
//  6 rst_n low mid-MEAS_LOW -> outputs 0 asynchronously (before next clk_in edge).

Source files
------------

// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared state encoding and default sizing for clk_period_monitor
package clk_mon_pkg;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_LOCK_CNT    = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - synchronizer chain plus single-cycle rise/fall detection
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= w_s;
    end
  end

  assign o_s    = w_s;
  assign o_rise = w_s & ~r_prev;
  assign o_fall = ~w_s & r_prev;

endmodule

// File: rtl/clk_period_monitor.sv
// rtl/clk_period_monitor.sv - measures period/high time of a divided clock and reports lock
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             overflow
);

  localparam int              MW       = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_overflow;
  logic [MW-1:0]    r_match;
  logic [MW-1:0]    w_match_next;
  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_cap_hi;
  logic             w_meas;
  logic             w_ovf;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk  (clk_in),
    .i_rst_n(rst_n),
    .i_sig  (sig_in),
    .o_s    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // clr wins over any edge or saturation seen in the same cycle
  always_comb begin
    w_next   = r_state;
    w_cap_hi = 1'b0;
    w_meas   = 1'b0;
    w_ovf    = 1'b0;
    if (clr) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise && w_s) w_next = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            w_cap_hi = 1'b1;
            w_next   = MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            w_meas = 1'b1;
            w_next = MEAS_HIGH;
          end
        end
        default: w_next = IDLE;
      endcase
      if ((r_state != IDLE) && (r_cnt == CNT_MAX) && !w_rise && !w_fall) begin
        w_ovf    = 1'b1;
        w_cap_hi = 1'b0;
        w_meas   = 1'b0;
        w_next   = IDLE;
      end
    end
  end

  always_comb begin
    w_match_next = MATCH_ONE;
    if ((r_match != '0) && (r_cnt == r_period)) begin
      w_match_next = (r_match == LOCK_VAL) ? LOCK_VAL : r_match + MATCH_ONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_hi_cap     <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
      r_match      <= '0;
    end else if (clr) begin
      r_cnt        <= '0;
      r_hi_cap     <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
      r_match      <= '0;
    end else begin
      r_meas_valid <= w_meas;
      if (w_rise) begin
        r_cnt <= CNT_ONE;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_cap_hi) r_hi_cap <= r_cnt;
      if (w_meas) begin
        r_period    <= r_cnt;
        r_high_time <= r_hi_cap;
        r_match     <= w_match_next;
        r_locked    <= (w_match_next == LOCK_VAL);
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
        r_locked   <= 1'b0;
        r_match    <= '0;
      end
    end
  end

  assign meas_valid = r_meas_valid;
  assign period     = r_period;
  assign high_time  = r_high_time;
  assign locked     = r_locked;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb/tb_clk_period_monitor.sv - directed self-checking bench for clk_period_monitor
module tb_clk_period_monitor;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sig_in = 1'b0;
  logic       clr    = 1'b0;
  logic       meas_valid;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       locked;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mv_cnt   = 0;
  int mv_last  = 0;
  int mv_gap   = 0;
  int mv_snap  = 0;

  clk_period_monitor #(
    .CNT_W      (8),
    .LOCK_CNT   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .clr       (clr),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      mv_gap  = cyc - mv_last;
      mv_last = cyc;
    end
  endtask

  task automatic hold(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = level;
      step();
    end
  endtask

  task automatic drive_period(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      sig_in = (i < hi);
      step();
    end
  endtask

  initial begin
    // 1: reset held while sig_in toggles
    for (int i = 0; i < 6; i++) begin
      sig_in = ~sig_in;
      step();
      chk("reset_outputs_zero", {13'd0, meas_valid, locked, overflow, period, high_time}, 32'd0);
    end
    rst_n = 1'b1;
    hold(1'b0, 4);

    // 2: 8-cycle clock, 4 high
    drive_period(8, 4);
    chk("no_meas_after_first_rise", mv_cnt, 0);
    drive_period(8, 4);
    chk("first_meas_count", mv_cnt, 1);
    chk("p8_period", period, 8);
    chk("p8_high", high_time, 4);
    chk("p8_locked_meas1", locked, 0);
    drive_period(8, 4);
    drive_period(8, 4);
    chk("p8_locked_meas3", locked, 0);
    drive_period(8, 4);
    chk("p8_meas_count4", mv_cnt, 4);
    chk("p8_locked_meas4", locked, 1);
    chk("p8_meas_gap", mv_gap, 8);

    // 3: switch to 10-cycle clock, 3 high
    drive_period(10, 3);
    chk("p10_prev_period8", period, 8);
    chk("p10_prev_locked", locked, 1);
    drive_period(10, 3);
    chk("p10_period", period, 10);
    chk("p10_high", high_time, 3);
    chk("p10_unlock_on_change", locked, 0);
    drive_period(10, 3);
    drive_period(10, 3);
    chk("p10_locked_meas3", locked, 0);
    drive_period(10, 3);
    chk("p10_relock", locked, 1);
    chk("p10_meas_gap", mv_gap, 10);
    chk("p10_overflow_clear", overflow, 0);

    // 4: stuck high -> overflow
    hold(1'b1, 10);
    mv_snap = mv_cnt;
    hold(1'b1, 290);
    chk("ovf_no_meas", mv_cnt, mv_snap);
    chk("ovf_set", overflow, 1);
    chk("ovf_unlocked", locked, 0);
    hold(1'b0, 5);
    mv_snap = mv_cnt;
    drive_period(8, 4);
    chk("ovf_idle_first_rise", mv_cnt, mv_snap);
    drive_period(8, 4);
    chk("ovf_resume_count", mv_cnt, mv_snap + 1);
    chk("ovf_resume_period", period, 8);
    chk("ovf_resume_high", high_time, 4);
    chk("ovf_sticky", overflow, 1);

    // 5: clr in the same cycle as the rise pulse (state is MEAS_LOW here)
    sig_in = 1'b1;
    step();
    step();
    clr = 1'b1;
    mv_snap = mv_cnt;
    step();
    clr = 1'b0;
    chk("clr_outputs_zero", {13'd0, meas_valid, locked, overflow, period, high_time}, 32'd0);
    hold(1'b1, 1);
    hold(1'b0, 4);
    chk("clr_no_meas", mv_cnt, mv_snap);
    drive_period(8, 4);
    chk("clr_first_rise_no_meas", mv_cnt, mv_snap);
    drive_period(8, 4);
    chk("clr_second_rise_meas", mv_cnt, mv_snap + 1);
    chk("clr_period", period, 8);
    chk("clr_overflow_zero", overflow, 0);

    // high time of one cycle
    drive_period(5, 1);
    drive_period(5, 1);
    chk("hi1_period", period, 5);
    chk("hi1_high", high_time, 1);

    // 6: async reset while in MEAS_LOW
    hold(1'b1, 4);
    hold(1'b0, 3);
    chk("pre_reset_period", period, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {13'd0, meas_valid, locked, overflow, period, high_time}, 32'd0);
    #2;
    rst_n = 1'b1;
    hold(1'b0, 4);
    mv_snap = mv_cnt;
    drive_period(6, 2);
    drive_period(6, 2);
    chk("post_reset_meas", mv_cnt, mv_snap + 1);
    chk("post_reset_period", period, 6);
    chk("post_reset_high", high_time, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
